// File: rtl/l2_cache_sweep_ctrl.sv
// L2 whole-cache maintenance sequencer: walks every set/way, issues one flush/invalidate
// per line, drains the pipeline, then pulses done. Optional stall statistics: L2_SWEEP_STATS_EN.
`ifndef L2_SETS
`define L2_SETS 64
`endif
`ifndef L2_WAYS
`define L2_WAYS 8
`endif

module l2_cache_sweep_ctrl #(
  parameter int NUM_SETS   = `L2_SETS,
  parameter int NUM_WAYS   = `L2_WAYS,
  parameter int PIPE_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_en,
  input  logic [1:0]                  start_op,
  input  logic                        abort_en,
  input  logic                        writeback_pending,
  output logic                        sweep_valid,
  input  logic                        sweep_ready,
  output logic [$clog2(NUM_SETS)-1:0] sweep_set,
  output logic [$clog2(NUM_WAYS)-1:0] sweep_way,
  output logic [1:0]                  sweep_op,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted,
  output logic [31:0]                 sweep_stall_count
);

  // state | meaning
  // IDLE  | waiting for start_en
  // SWEEP | issuing one request per set/way
  // DRAIN | waiting for pipeline depth and writeback queue to empty
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  localparam int SW = $clog2(NUM_SETS);
  localparam int WW = $clog2(NUM_WAYS);

  state_t     state, state_nxt;
  logic [3:0] drain_cnt, drain_dec;
  logic       abort_flag;
  logic       accept, last_line, way_wrap, start_acc;

  always_comb begin
    accept    = (state == SWEEP) && sweep_ready;
    way_wrap  = (sweep_way == WW'(NUM_WAYS - 1));
    last_line = way_wrap && (sweep_set == SW'(NUM_SETS - 1));
    start_acc = (state == IDLE) && start_en;
    drain_dec = (drain_cnt == 4'd0) ? 4'd0 : drain_cnt - 4'd1;
  end

  // DRAIN exits when the count is about to reach zero, so it lasts PIPE_DEPTH cycles minimum
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_en) state_nxt = SWEEP;
      SWEEP: if (accept && (last_line || abort_flag || abort_en)) state_nxt = DRAIN;
      DRAIN: if ((drain_dec == 4'd0) && !writeback_pending) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      drain_cnt   <= 4'd0;
      abort_flag  <= 1'b0;
      sweep_set   <= '0;
      sweep_way   <= '0;
      sweep_op    <= 2'd0;
      sweep_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state       <= state_nxt;
      sweep_valid <= (state_nxt == SWEEP);
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
      aborted     <= (state_nxt == DONE) && abort_flag;
      case (state)
        IDLE: begin
          if (start_en) begin
            sweep_op   <= (start_op == 2'd3) ? 2'd0 : start_op;
            sweep_set  <= '0;
            sweep_way  <= '0;
            abort_flag <= 1'b0;
          end
        end
        SWEEP: begin
          if (abort_en) abort_flag <= 1'b1;
          if (accept) begin
            sweep_way <= sweep_way + WW'(1);
            if (way_wrap) sweep_set <= sweep_set + SW'(1);
          end
          if (state_nxt == DRAIN) drain_cnt <= 4'(PIPE_DEPTH);
        end
        DRAIN: drain_cnt <= drain_dec;
        default: ;
      endcase
    end
  end

`ifdef L2_SWEEP_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sweep_stall_count <= 32'd0;
    end else if (start_acc) begin
      sweep_stall_count <= 32'd0;
    end else if ((state == SWEEP) && !sweep_ready && (sweep_stall_count != 32'hFFFF_FFFF)) begin
      sweep_stall_count <= sweep_stall_count + 32'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats      = start_acc;
  assign sweep_stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_l2_cache_sweep_ctrl.sv
// Directed bench for l2_cache_sweep_ctrl: scoreboard of expected requests checked on each
// accept, plus completion timing, abort, drain hold, start filtering and reset checks.
module tb_l2_cache_sweep_ctrl;
  localparam int NS = 4;
  localparam int NW = 2;
  localparam int PD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_en = 1'b0;
  logic [1:0] start_op = 2'd0;
  logic       abort_en = 1'b0;
  logic       writeback_pending = 1'b0;
  logic       sweep_valid;
  logic       sweep_ready = 1'b0;
  logic [1:0] sweep_set;
  logic [0:0] sweep_way;
  logic [1:0] sweep_op;
  logic       busy, done, aborted;
  logic [31:0] sweep_stall_count;

  l2_cache_sweep_ctrl #(.NUM_SETS(NS), .NUM_WAYS(NW), .PIPE_DEPTH(PD)) dut (
    .clk(clk), .reset(reset), .start_en(start_en), .start_op(start_op),
    .abort_en(abort_en), .writeback_pending(writeback_pending),
    .sweep_valid(sweep_valid), .sweep_ready(sweep_ready),
    .sweep_set(sweep_set), .sweep_way(sweep_way), .sweep_op(sweep_op),
    .busy(busy), .done(done), .aborted(aborted),
    .sweep_stall_count(sweep_stall_count)
  );

  always #5 clk = ~clk;

  typedef struct { int s; int w; int op; } req_t;
  req_t q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int accepts = 0;
  int last_acc = -1;
  int done_cnt = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endfunction

  // request monitor: pops the scoreboard on each accept, checks stability while stalled
  logic       held = 1'b0;
  logic [1:0] h_set, h_op;
  logic [0:0] h_way;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (reset || !sweep_valid) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_hold_set", sweep_set, h_set);
        chk("stall_hold_way", sweep_way, h_way);
        chk("stall_hold_op", sweep_op, h_op);
      end
      if (sweep_ready) begin
        chk("sb_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          req_t e;
          e = q.pop_front();
          chk("req_set", sweep_set, e.s);
          chk("req_way", sweep_way, e.w);
          chk("req_op", sweep_op, e.op);
        end
        accepts++;
        last_acc = cyc;
        held = 1'b0;
      end else begin
        held = 1'b1;
        h_set = sweep_set; h_way = sweep_way; h_op = sweep_op;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_lines(int op, int n);
    for (int i = 0; i < n; i++) begin
      req_t e;
      e.s = i / NW; e.w = i % NW; e.op = op;
      q.push_back(e);
    end
  endtask

  task automatic wait_done(output int dc, output logic ab);
    dc = -1; ab = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin dc = cyc; ab = aborted; break; end
    end
    vectors++;
    assert (dc != -1) else begin
      miscompares++;
      $error("FAIL done_timeout: observed no done expected done within 200 cycles");
    end
  endtask

  task automatic after_done();
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_cleared", busy, 0);
  endtask

  int T, dc, a0, dcnt0;
  logic ab;
  int exp_stall;

  initial begin
    // reset
    repeat (3) @(negedge clk);
    chk("rst_valid", sweep_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_set", sweep_set, 0);
    chk("rst_way", sweep_way, 0);
    chk("rst_op", sweep_op, 0);
    chk("rst_stall", sweep_stall_count, 0);
    step(); reset = 1'b0;
    step();

    // full flush, ready held high
    sweep_ready = 1'b1;
    push_lines(0, NS * NW);
    a0 = accepts;
    step(); start_en = 1'b1; start_op = 2'd0; T = cyc;
    step(); start_en = 1'b0;
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_valid", sweep_valid, 1);
    wait_done(dc, ab);
    chk("t1_done_cycle", dc, T + NS * NW + PD + 1);
    chk("t1_aborted", ab, 0);
    chk("t1_accepts", accepts - a0, NS * NW);
    chk("t1_last_accept", last_acc, T + NS * NW);
    after_done();
    chk("t1_sb_empty", q.size(), 0);

    // backpressure 1,0,0 with op 2; start_op=1 pulse mid-sweep must be ignored
    push_lines(2, NS * NW);
    a0 = accepts;
    step(); start_en = 1'b1; start_op = 2'd2; T = cyc;
    for (int k = 0; k < 22; k++) begin
      step();
      start_en = (k == 1);
      start_op = (k == 1) ? 2'd1 : 2'd2;
      sweep_ready = ((k % 3) == 0);
    end
    step(); start_en = 1'b0; sweep_ready = 1'b1;
    wait_done(dc, ab);
    chk("bp_done_cycle", dc, T + 22 + PD + 1);
    chk("bp_accepts", accepts - a0, NS * NW);
    chk("bp_aborted", ab, 0);
`ifdef L2_SWEEP_STATS_EN
    exp_stall = 14;
`else
    exp_stall = 0;
`endif
    after_done();
    chk("bp_stall_count", sweep_stall_count, exp_stall);

    // abort while stalled on (1,0), op 1
    push_lines(1, 3);
    a0 = accepts;
    step(); start_en = 1'b1; start_op = 2'd1; T = cyc;
    step(); start_en = 1'b0; sweep_ready = 1'b1;   // T+1 accept (0,0)
    step();                                         // T+2 accept (0,1)
    step(); sweep_ready = 1'b0; abort_en = 1'b1;   // T+3 stalled on (1,0)
    step(); abort_en = 1'b0;                        // T+4 still stalled
    step(); sweep_ready = 1'b1;                     // T+5 accept (1,0)
    wait_done(dc, ab);
    chk("ab_done_cycle", dc, T + 5 + PD + 1);
    chk("ab_aborted", ab, 1);
    chk("ab_accepts", accepts - a0, 3);
`ifdef L2_SWEEP_STATS_EN
    exp_stall = 2;
`else
    exp_stall = 0;
`endif
    chk("ab_stall_count", sweep_stall_count, exp_stall);
    after_done();
    chk("ab_sb_empty", q.size(), 0);

    // drain hold: writeback pending for 10 cycles after the last accept
    push_lines(0, NS * NW);
    step(); start_en = 1'b1; start_op = 2'd0; T = cyc;
    step(); start_en = 1'b0;
    while (cyc < T + NS * NW + 10) begin
      step();
      writeback_pending = (cyc >= T + NS * NW + 1) && (cyc <= T + NS * NW + 10);
    end
    step(); writeback_pending = 1'b0;
    wait_done(dc, ab);
    chk("dh_done_cycle", dc, T + NS * NW + 12);
    chk("dh_aborted", ab, 0);
    after_done();

    // op 3 maps to flush; reset after 3 accepts
    push_lines(0, 3);
    dcnt0 = done_cnt;
    step(); start_en = 1'b1; start_op = 2'd3; T = cyc;
    step(); start_en = 1'b0;
    step(); step();
    step(); sweep_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("mr_valid", sweep_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_set", sweep_set, 0);
    chk("mr_way", sweep_way, 0);
    chk("mr_op", sweep_op, 0);
    chk("mr_sb_empty", q.size(), 0);
    step(); reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("mr_no_done", done_cnt - dcnt0, 0);
    chk("mr_idle_valid", sweep_valid, 0);

    // restart from (0,0) after reset
    push_lines(1, NS * NW);
    a0 = accepts;
    step(); start_en = 1'b1; start_op = 2'd1; sweep_ready = 1'b1; T = cyc;
    step(); start_en = 1'b0;
    wait_done(dc, ab);
    chk("rs_done_cycle", dc, T + NS * NW + PD + 1);
    chk("rs_accepts", accepts - a0, NS * NW);
    after_done();
    chk("rs_sb_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
